// File: rtl/ifetch_seq_if.sv
// ifetch_seq_if: instruction-memory fetch handshake.
//   req   - fetch request, held until ack
//   addr  - word address, stable while req is high
//   ack   - rdata valid this cycle
//   rdata - fetched instruction word
// master: fetch stage side. slave: instruction memory side.
interface ifetch_seq_if #(
  parameter int IMEM_AW = 14
);
  logic               req;
  logic [IMEM_AW-1:0] addr;
  logic               ack;
  logic [31:0]        rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_seq.sv
// ifetch_seq: sequential instruction-fetch stage.
// Holds the PC, fetches one instruction per retire over the imem
// handshake and presents Instruction/opcplus4 stable to decode until
// issue_ready retires it. The next PC is chosen from jr/jump/branch at the
// retire edge.
//
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   imem (master)       - req/addr/ack/rdata fetch handshake
//   issue_ready         - datapath retires the held instruction
//   Jmp, Jal, Jr        - jump decodes of the held instruction
//   branch_taken        - conditional branch resolved taken
//   Addr_result         - branch target
//   read_data_1         - jr target (rs)
//   instr_valid         - Instruction/opcplus4 valid for decode
//   Instruction         - held instruction
//   opcplus4            - PC+4 of the held instruction
//   pc                  - address of held/pending instruction
//   fault               - fetch fault
//
// Optional feature macro: IFETCH_FAULT_EN. When defined, a misaligned or
// out-of-range next PC parks the stage in FAULT until reset. When not
// defined, fault is tied 0 and such bits are simply dropped from imem.addr.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  ifetch_seq_if.master       imem,
  input  logic               issue_ready,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               branch_taken,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        read_data_1,
  output logic               instr_valid,
  output logic [31:0]        Instruction,
  output logic [31:0]        opcplus4,
  output logic [31:0]        pc,
  output logic               fault
);

`ifdef IFETCH_FAULT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] next_pc;
  logic        bad_pc;

  // Jr wins over jump, jump over branch, otherwise sequential.
  always_comb begin
    next_pc = pc + 32'd4;
    if (Jr)                next_pc = read_data_1;
    else if (Jmp || Jal)   next_pc = {opcplus4[31:28], Instruction[25:0], 2'b00};
    else if (branch_taken) next_pc = Addr_result;
  end

`ifdef IFETCH_FAULT_EN
  // Unaligned, or any bit beyond what imem.addr can carry.
  assign bad_pc = (next_pc[1:0] != 2'b00) || ((next_pc >> (IMEM_AW + 2)) != 32'd0);
`else
  assign bad_pc = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      Instruction <= 32'd0;
      opcplus4    <= 32'd0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (imem.ack) begin
          Instruction <= imem.rdata;
          opcplus4    <= pc + 32'd4;
          state       <= HOLD;
        end
        HOLD: if (issue_ready) begin
          pc <= next_pc;
`ifdef IFETCH_FAULT_EN
          state <= bad_pc ? FAULT : FETCH;
`else
          state <= FETCH;
`endif
        end
`ifdef IFETCH_FAULT_EN
        FAULT: state <= FAULT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of the state register; pc only moves at the
  // retire edge so addr is stable for the whole request.
  assign imem.req    = (state == FETCH);
  assign imem.addr   = pc[IMEM_AW+1:2];
  assign instr_valid = (state == HOLD);
`ifdef IFETCH_FAULT_EN
  assign fault       = (state == FAULT);
`else
  assign fault       = 1'b0;
`endif

  // bad_pc only matters when the fault feature is built in.
  logic unused_ok;
  assign unused_ok = bad_pc;

endmodule

// File: tb/tb_ifetch_seq.sv
module tb_ifetch_seq;
  localparam int AW = 14;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_ready = 1'b0;
  logic        Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, branch_taken = 1'b0;
  logic [31:0] Addr_result = '0, read_data_1 = '0;
  logic        instr_valid, fault;
  logic [31:0] Instruction, opcplus4, pc;

  ifetch_seq_if #(.IMEM_AW(AW)) imem_bus ();

  ifetch_seq #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clock(clock), .reset(reset), .imem(imem_bus),
    .issue_ready(issue_ready), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
    .branch_taken(branch_taken), .Addr_result(Addr_result),
    .read_data_1(read_data_1), .instr_valid(instr_valid),
    .Instruction(Instruction), .opcplus4(opcplus4), .pc(pc), .fault(fault)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // reference model: what decode should currently see
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_op4 = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return (a / 4) % (32'd1 << AW);
  endfunction

  // Wait for the request, optionally stretch it, then ack with data.
  task automatic serve(input int lat, input logic [31:0] data);
    int n = 0;
    while (imem_bus.req !== 1'b1 && n < 8) begin tick; n++; end
    check("req_seen", 32'(imem_bus.req), 32'd1);
    check("req_addr", 32'(imem_bus.addr), word_addr(m_pc));
    for (int i = 0; i < lat; i++) begin
      tick;
      check("wait_req", 32'(imem_bus.req), 32'd1);
      check("wait_addr", 32'(imem_bus.addr), word_addr(m_pc));
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_bus.ack = 1'b1;
    imem_bus.rdata = data;
    tick;
    imem_bus.ack = 1'b0;
    imem_bus.rdata = $urandom;
    m_instr = data;
    m_op4 = m_pc + 32'd4;
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_req", 32'(imem_bus.req), 32'd0);
    check("hold_instr", Instruction, m_instr);
    check("hold_op4", opcplus4, m_op4);
    check("hold_pc", pc, m_pc);
  endtask

  // issue_ready low: everything frozen even with noisy controls and stray acks.
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      Jr = 1'($urandom); Jmp = 1'($urandom); Jal = 1'($urandom);
      branch_taken = 1'($urandom);
      read_data_1 = $urandom; Addr_result = $urandom;
      imem_bus.ack = 1'b1; imem_bus.rdata = $urandom;
      tick;
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_bus.req), 32'd0);
      check("stall_instr", Instruction, m_instr);
      check("stall_op4", opcplus4, m_op4);
      check("stall_pc", pc, m_pc);
    end
    Jr = 0; Jmp = 0; Jal = 0; branch_taken = 0; imem_bus.ack = 1'b0;
  endtask

  task automatic retire(input logic jr, input logic jmp, input logic jal, input logic br,
                        input logic [31:0] rd1, input logic [31:0] ar);
    logic [31:0] npc;
    logic        bad;
    if (jr)              npc = rd1;
    else if (jmp || jal) npc = ((m_pc + 32'd4) & 32'hF000_0000) + (m_instr % (32'd1 << 26)) * 4;
    else if (br)         npc = ar;
    else                 npc = m_pc + 32'd4;
    bad = 1'b0;
`ifdef IFETCH_FAULT_EN
    bad = (npc % 4 != 0) || (npc >= (32'd4 << AW));
`endif
    Jr = jr; Jmp = jmp; Jal = jal; branch_taken = br;
    read_data_1 = rd1; Addr_result = ar; issue_ready = 1'b1;
    tick;
    issue_ready = 1'b0; Jr = 0; Jmp = 0; Jal = 0; branch_taken = 0;
    m_pc = npc;
    check("ret_pc", pc, m_pc);
    check("ret_fault", 32'(fault), 32'(bad));
    check("ret_req", 32'(imem_bus.req), 32'(!bad));
    check("ret_valid", 32'(instr_valid), 32'd0);
    if (!bad) check("ret_addr", 32'(imem_bus.addr), word_addr(m_pc));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_instr"}, Instruction, 32'h0);
    check({tag, "_op4"}, opcplus4, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_req"}, 32'(imem_bus.req), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_addr"}, 32'(imem_bus.addr), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    imem_bus.ack = 1'b0;
    imem_bus.rdata = '0;

    // reset and first request
    tick; tick;
    check_reset_vals("rst");
    reset = 1'b0;
    check("idle_req", 32'(imem_bus.req), 32'd0);

    // zero-wait memory, ack and issue_ready held high: 1 instr / 2 cycles
    imem_bus.ack = 1'b1;
    issue_ready = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      check("zw_req", 32'(imem_bus.req), 32'd1);
      check("zw_addr", 32'(imem_bus.addr), 32'(k));
      check("zw_valid_lo", 32'(instr_valid), 32'd0);
      d = $urandom;
      imem_bus.rdata = d;
      tick;
      check("zw_valid_hi", 32'(instr_valid), 32'd1);
      check("zw_op4", opcplus4, 32'(4 * (k + 1)));
      check("zw_instr", Instruction, d);
      imem_bus.rdata = ~d;
      tick;
    end
    imem_bus.ack = 1'b0;
    issue_ready = 1'b0;
    m_pc = 32'd12;

    // ack delayed three cycles, then a 5-cycle stall in HOLD
    serve(3, $urandom & 32'hFC00_3FFF);
    stall(5);

    // jal via the held instruction
    retire(1, 0, 0, 0, 32'h10, 32'h0);
    serve(0, 32'h0C00_0040);
    check("jal_op4", opcplus4, 32'h14);
    retire(0, 0, 1, 0, 32'h0, 32'h0);
    check("jal_pc", pc, 32'h100);
    check("jal_addr", 32'(imem_bus.addr), 32'h40);

    // jr beats branch, then branch alone
    serve(1, $urandom & 32'hFC00_3FFF);
    retire(1, 0, 0, 1, 32'h24, 32'h80);
    check("jr_pc", pc, 32'h24);
    serve(0, $urandom & 32'hFC00_3FFF);
    retire(0, 0, 0, 1, 32'h24, 32'h80);
    check("br_pc", pc, 32'h80);

    // randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      serve(int'($urandom_range(0, 3)), $urandom & 32'hFC00_3FFF);
      stall(int'($urandom_range(0, 2)));
      retire(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
             ($urandom % 3) == 0, $urandom & 32'h0000_FFFC, $urandom & 32'h0000_FFFC);
    end

    // reset in the middle of a request; the late ack must be dropped
    tick;
    check("mid_req", 32'(imem_bus.req), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    imem_bus.ack = 1'b1;
    imem_bus.rdata = 32'hDEAD_BEEF;
    tick;
    reset = 1'b0;
    tick;
    imem_bus.ack = 1'b0;
    check("late_ack_instr", Instruction, 32'h0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    m_pc = 32'h0;
    serve(0, $urandom & 32'hFC00_3FFF);

`ifdef IFETCH_FAULT_EN
    retire(1, 0, 0, 0, 32'h26, 32'h0);
    for (int i = 0; i < 10; i++) begin
      imem_bus.ack = 1'b1;
      issue_ready = 1'b1;
      tick;
      check("flt_fault", 32'(fault), 32'd1);
      check("flt_req", 32'(imem_bus.req), 32'd0);
      check("flt_valid", 32'(instr_valid), 32'd0);
      check("flt_pc", pc, 32'h26);
    end
    imem_bus.ack = 1'b0;
    issue_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("flt_rst");
    tick;
    reset = 1'b0;
    tick;
`else
    // stray low / high bits are dropped from the address, no fault
    retire(1, 0, 0, 0, 32'h26, 32'h0);
    check("drop_lo_addr", 32'(imem_bus.addr), 32'd9);
    serve(0, $urandom & 32'hFC00_3FFF);
    check("drop_lo_op4", opcplus4, 32'h2A);
    retire(1, 0, 0, 0, 32'h0001_0004, 32'h0);
    check("drop_hi_addr", 32'(imem_bus.addr), 32'd1);
    serve(0, $urandom & 32'hFC00_3FFF);
    // pc+4 wraps at the top of the address space
    retire(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
    check("top_addr", 32'(imem_bus.addr), 32'h3FFF);
    serve(2, $urandom & 32'hFC00_3FFF);
    check("wrap_op4", opcplus4, 32'h0);
    retire(0, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // hard stop so a wedged DUT cannot hang the run
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifetch_seq.md
# ifetch_seq

Sequential instruction-fetch stage sitting directly upstream of the register-file/decode stage. It holds the program counter, fetches one 32-bit instruction per retire from a variable-latency instruction memory over a req/ack handshake, and presents `Instruction` and `opcplus4` stable to decode until the datapath signals retirement. On retirement it computes the next PC from the jump, branch and jr controls.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_AW`, 14, instruction-memory word-address width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request; held until ack.
- `imem_addr`  out  IMEM_AW  word address, `pc[IMEM_AW+1:2]`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `issue_ready`  in  1  datapath retires the held instruction this cycle.
- `Jmp`, `Jal`, `Jr`  in  1 each  control-unit jump decodes for the held instruction.
- `branch_taken`  in  1  conditional branch resolved taken.
- `Addr_result`  in  32  branch target from execute.
- `read_data_1`  in  32  rs value from register file (jr target).
- `instr_valid`  out  1  `Instruction`/`opcplus4` valid for decode.
- `Instruction`  out  32  held instruction.
- `opcplus4`  out  32  PC+4 of held instruction (jal link value).
- `pc`  out  32  address of held/pending instruction.
- `fault`  out  1  fetch fault (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, FAULT. Reset state IDLE.
- IDLE: unconditionally → FETCH on next edge.
- FETCH: `imem_req`=1, `imem_addr` from `pc`, both stable. On edge with `imem_ack`=1: capture `imem_rdata`→`Instruction`, `pc+4`→`opcplus4`, → HOLD. Otherwise stay.
- HOLD: `instr_valid`=1, `imem_req`=0. Edge with `issue_ready`=1: load next PC, → FETCH. Otherwise outputs frozen.
- Next PC priority, sampled at retire edge: `Jr` → `read_data_1`; else `Jmp`|`Jal` → {opcplus4[31:28], Instruction[25:0], 2'b00}; else `branch_taken` → `Addr_result`; else `pc+4`.
- Arithmetic: `pc+4` modulo 2^32; 0xFFFF_FFFC wraps to 0.
- Control inputs ignored outside HOLD or when `issue_ready`=0.
- `imem_req`, `instr_valid` are decoded from registered state (glitch-free).

## Timing
- Reset values: `pc`=RESET_PC, `Instruction`=0, `opcplus4`=0, `instr_valid`=0, `imem_req`=0, `fault`=0, `imem_addr`=RESET_PC[IMEM_AW+1:2].
- First request: cycle 1 after reset deassert (IDLE→FETCH edge).
- Ack may arrive in the first request cycle; zero-wait fetch: `instr_valid` high the cycle after ack.
- Throughput with zero-wait memory and `issue_ready` held high: one instruction per 2 cycles.
- Each extra wait cycle adds one cycle; `imem_addr` must not change while `imem_req`=1.
- `imem_ack` while `imem_req`=0 is ignored.
- Reset mid-fetch: outputs return to reset values immediately; a late ack is dropped; memory must tolerate an abandoned request.

## Configuration
- `IFETCH_FAULT_EN` defined: at the retire edge, if the selected next PC has `[1:0]`≠0 or any bit above `IMEM_AW+1` set, go to FAULT instead of FETCH: `fault`=1, `imem_req`=0, `instr_valid`=0, `pc` holds the offending value; exit only via reset.
- Not defined: no FAULT state; `fault` tied 0; low 2 bits and out-of-range upper bits are silently dropped from `imem_addr`.

## Test plan
- Reset, RESET_PC=0, memory acks same cycle, `issue_ready`=1: `imem_addr` 0,1,2; `opcplus4` 4,8,12; `instr_valid` pulses every 2 cycles.
- Ack delayed 3 cycles: `imem_req` high 4 cycles with address constant; `instr_valid` rises exactly one cycle after ack.
- `issue_ready` low 5 cycles in HOLD: `Instruction`, `pc`, `opcplus4` unchanged; `imem_req` stays 0.
- `pc`=0x10, `Instruction`=0x0C000040, `Jal`=1, retire: next `imem_addr`=0x40 (pc 0x100); `opcplus4`=0x14 during HOLD.
- `Jr`=1 with `read_data_1`=0x24 and `branch_taken`=1, `Addr_result`=0x80: next pc=0x24; repeat with `Jr`=0: pc=0x80.
- `IFETCH_FAULT_EN` defined, jr to 0x26: `fault`=1, `imem_req` stays 0 for 10 cycles; assert reset: `fault`=0, `pc`=RESET_PC.
